instr_stream_feeder: RTL
========================

// Module: instr_stream_feeder
// PURPOSE
//  Parametrised instruction source for IF->ID bring-up: a host loads a program image into internal
//  word RAM over a valid/ready port, then the block plays it into the ID-stage interface (instr,
//  next_pc, exc_code) honouring stall and branch redirect. It appends NOP padding and flags done.
//  It replaces the fixed sequential testbench feeder and is synthesizable, so it also runs on the board.
// PARAMETERS
//  DEPTH_LOG2  12  log2 of image RAM depth in 32-bit words (DEPTH = 1<<DEPTH_LOG2).
//  PAD_NOPS    4   number of zero words emitted after the last image word before done.
//  RESET_PC    0   byte address of the first fetched instruction after start.
// PORTS
//  clk            in   1    system clock
//  rst_n          in   1    asynchronous active-low reset
//  load_valid     in   1    host image word valid
//  load_data      in   32   image word, file byte order
//  load_last      in   1    marks final image word
//  load_ready     out  1    block accepts image word
//  start          in   1    one-cycle pulse: begin playback from RESET_PC
//  stall          in   1    ID stage stall; hold all outputs
//  redirect_valid in   1    branch/jump taken; refetch from redirect_pc
//  redirect_pc    in   32   byte target address
//  out_valid      out  1    instr/next_pc/exc_code valid this cycle
//  out_instr      out  32   instruction word, CPU byte order
//  out_next_pc    out  32   byte address of fetched instruction + 4
//  out_exc_code   out  5    `EC_NONE, or `EC_ADEL on bad fetch address
//  nr_words       out  DEPTH_LOG2+1  image words loaded
//  done           out  1    playback finished; sticky until reset/start
// BEHAVIOUR
//  Reset (async, rst_n=0): state LOAD; load_ready=1, out_valid=0, out_instr=0, out_next_pc=0,
//   out_exc_code=`EC_NONE, nr_words=0, done=0. Reset mid-playback or mid-load has the same effect.
//  FSM: LOAD -(load_last accepted, or start)-> IDLE -(start)-> RUN -(pc past image)-> PAD -(PAD_NOPS sent)-> DONE.
//   start while in DONE re-enters RUN at RESET_PC with the image retained and done cleared.
//  LOAD: word written at nr_words when load_valid&&load_ready; nr_words++.
//   load_ready=0 once nr_words==DEPTH; further words are refused, not wrapped.
//   A write and load_last in the same cycle counts that word.
//  RUN: synchronous RAM read, 1-cycle latency: pc issued at cycle N appears on outputs at N+1.
//   Each non-stalled cycle pc+=4; out_next_pc=pc+4 of the displayed word.
//  stall=1: outputs and pc frozen; RAM re-read of the same address permitted.
//  redirect_valid (ignored while stall=1): next issued pc=redirect_pc; the word in flight is dropped
//   (out_valid=0 for 1 cycle). redirect_pc[1:0]!=0 -> one output with out_instr=0 and
//   out_exc_code=`EC_ADEL, then continue at redirect_pc&~3.
//  Redirect beyond the image (word index>=nr_words) enters PAD immediately.
//  PAD: emits PAD_NOPS words of 0 with incrementing next_pc, then DONE.
//   A redirect during PAD back inside the image returns to RUN.
//  DONE: out_valid=0, done=1. Empty image (nr_words=0) plus start goes straight to PAD.
// CONFIGURATION
//  INSTR_STREAM_FEEDER_BSWAP_EN defined: load_data byte-reversed on write ({b0,b1,b2,b3}) for
//   little-endian host images. Undefined: words stored as given.
// STRUCTURE
//  Shared package/header (feeder_pkg.vh): FSM state encodings, PC width, NOP constant; EC codes from cp0_def.vh.
//  One sub-module: feeder_ram (1R1W synchronous, DEPTH_LOG2 address), so an FPGA block RAM can be substituted.
// TESTING
//  Load 3 words 0x01020304.. with BSWAP_EN, start -> out_instr 0x04030201.., next_pc 4,8,12, then 4 zeros, done=1.
//  stall high 3 cycles mid-run -> out_instr/out_next_pc unchanged for 3 cycles; no word skipped or repeated.
//  redirect_pc=0x8 at 3rd word -> one bubble, then word[2] with next_pc=0xC.
//  redirect_pc=0x6 -> out_exc_code=`EC_ADEL, instr 0; then word[1], next_pc 0x8.
//  Load DEPTH+2 words -> load_ready falls at DEPTH, nr_words=DEPTH; rst_n pulsed during RUN -> all outputs at reset values.
//  start with nr_words=0 -> PAD_NOPS zeros, next_pc 4..4*PAD_NOPS, done=1; second start replays.

Source files
------------

// File: rtl/instr_stream_feeder_pkg.sv
// Shared definitions for instr_stream_feeder: FSM encodings, output kinds,
// PC width, the NOP word and the exception codes on out_exc_code.
package instr_stream_feeder_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [4:0] EC_NONE = 5'd0;
  localparam logic [4:0] EC_ADEL = 5'd4;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_IDLE = 3'd1,
    ST_RUN  = 3'd2,
    ST_PAD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // What the output stage is currently presenting.
  typedef enum logic [1:0] {
    K_WORD = 2'd0,
    K_NOP  = 2'd1,
    K_EXC  = 2'd2
  } kind_t;

  // Reverse byte order of a 32-bit word.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/instr_stream_feeder_ram.sv
// 1R1W synchronous word RAM holding the program image. Read data is
// registered and only updates when rd_en is high, so the consumer can hold
// the last word simply by not reading. Written as a plain array so an FPGA
// block RAM can be inferred or substituted.
module instr_stream_feeder_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_stream_feeder.sv
// Instruction stream feeder: a host loads an image over a valid/ready port,
// then start plays it into the ID-stage interface with stall and redirect
// support, followed by PAD_NOPS zero words and a sticky done flag.
// Build option: define INSTR_STREAM_FEEDER_BSWAP_EN to byte-reverse each
// load_data word on write (little-endian host images).
//
// Handshake: an image word transfers on a rising clk edge where
// load_valid && load_ready; load_data/load_last are only meaningful then.
module instr_stream_feeder
  import instr_stream_feeder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          PAD_NOPS   = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  input  logic [31:0]         load_data,
  input  logic                load_last,
  output logic                load_ready,
  input  logic                start,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                out_valid,
  output logic [31:0]         out_instr,
  output logic [31:0]         out_next_pc,
  output logic [4:0]          out_exc_code,
  output logic [DEPTH_LOG2:0] nr_words,
  output logic                done,
  output logic [2:0]          dbg_state
);

  localparam int PAD_W = $clog2(PAD_NOPS + 2);
  localparam logic [PAD_W-1:0]    PAD_LIM   = PAD_W'(PAD_NOPS);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t            state, state_d;
  logic [PC_W-1:0]   pc, pc_d;
  logic [PAD_W-1:0]  pad_cnt, pad_d;
  logic              s_valid, s_valid_d;
  kind_t             s_kind, s_kind_d;
  logic [PC_W-1:0]   s_pc, s_pc_d;
  logic              rd_en;
  logic              load_fire;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic [31:0]       image_bytes;
  logic              in_image;

  assign load_ready  = (state == ST_LOAD) && (nr_words != DEPTH_CNT);
  assign load_fire   = load_valid && load_ready;
  assign image_bytes = {{(29-DEPTH_LOG2){1'b0}}, nr_words, 2'b00};
  assign in_image    = ({pc[31:2], 2'b00} < image_bytes);

`ifdef INSTR_STREAM_FEEDER_BSWAP_EN
  assign wr_data = bswap32(load_data);
`else
  assign wr_data = load_data;
`endif

  instr_stream_feeder_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .wr_en   (load_fire),
    .wr_addr (nr_words[DEPTH_LOG2-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (pc[DEPTH_LOG2+1:2]),
    .rd_data (rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_d;
  end

  // Next state, fetch pc and the content of the output stage.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pad_d     = pad_cnt;
    s_valid_d = s_valid;
    s_kind_d  = s_kind;
    s_pc_d    = s_pc;
    rd_en     = 1'b0;
    case (state)
      ST_LOAD: begin
        if (start || (load_fire && load_last)) state_d = ST_IDLE;
      end
      ST_IDLE, ST_DONE, ST_RUN, ST_PAD: begin
        if (start) begin
          state_d   = ST_RUN;
          pc_d      = RESET_PC;
          pad_d     = '0;
          s_valid_d = 1'b0;
        end else if ((state == ST_RUN || state == ST_PAD) && !stall) begin
          if (redirect_valid) begin
            // Drop the word issued this cycle; refetch from the target.
            s_valid_d = 1'b0;
            pc_d      = redirect_pc;
            pad_d     = '0;
            state_d   = ({redirect_pc[31:2], 2'b00} < image_bytes) ? ST_RUN : ST_PAD;
          end else if (pc[1:0] != 2'b00) begin
            // Misaligned target: one exception slot, then the aligned word.
            s_valid_d = 1'b1;
            s_kind_d  = K_EXC;
            s_pc_d    = pc;
            pc_d      = {pc[31:2], 2'b00};
          end else if (state == ST_RUN && in_image) begin
            s_valid_d = 1'b1;
            s_kind_d  = K_WORD;
            s_pc_d    = pc;
            rd_en     = 1'b1;
            pc_d      = pc + 32'd4;
          end else if (pad_cnt < PAD_LIM) begin
            s_valid_d = 1'b1;
            s_kind_d  = K_NOP;
            s_pc_d    = pc;
            pc_d      = pc + 32'd4;
            pad_d     = pad_cnt + PAD_W'(1);
            state_d   = ST_PAD;
          end else begin
            s_valid_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Fetch pc, pad counter, output stage and image word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      pad_cnt  <= '0;
      s_valid  <= 1'b0;
      s_kind   <= K_NOP;
      s_pc     <= '0;
      nr_words <= '0;
    end else begin
      pc      <= pc_d;
      pad_cnt <= pad_d;
      s_valid <= s_valid_d;
      s_kind  <= s_kind_d;
      s_pc    <= s_pc_d;
      if (load_fire) nr_words <= nr_words + 1'b1;
    end
  end

  assign out_valid    = s_valid;
  assign out_instr    = (s_valid && s_kind == K_WORD) ? rd_data : NOP_WORD;
  assign out_next_pc  = s_valid ? (s_pc + 32'd4) : 32'd0;
  assign out_exc_code = (s_valid && s_kind == K_EXC) ? EC_ADEL : EC_NONE;
  assign done         = (state == ST_DONE);
  assign dbg_state    = state;

endmodule
